// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// arm_pipe_pkg : shared types and constants for the ARM pipeline controller
// Rev 1.0
// ============================================================================
package arm_pipe_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // ID/EX control bundle; a bubble loads NOP_CTRL so nothing commits
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       s_upd;
    logic       branch;
    logic [3:0] exe_cmd;
  } idex_ctrl_t;

  localparam idex_ctrl_t NOP_CTRL = '0;

  function automatic logic src_hit(
    input logic                 used,
    input logic [REG_IDX_W-1:0] src,
    input logic [REG_IDX_W-1:0] dest,
    input logic                 wr
  );
    return used && wr && (src == dest);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : stage-register hazard/freeze/flush signal bundle
// Rev 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import arm_pipe_pkg::*;

  logic [REG_IDX_W-1:0] id_src1;
  logic                 id_src1_vld;
  logic [REG_IDX_W-1:0] id_src2;
  logic                 id_two_src;
  logic [REG_IDX_W-1:0] exe_dest;
  logic                 exe_wb_en;
  logic                 exe_mem_r_en;
  logic [REG_IDX_W-1:0] mem_dest;
  logic                 mem_wb_en;
  logic                 exe_branch;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 cnt_clr;

  logic                 pc_freeze;
  logic                 ifid_freeze;
  logic                 idex_bubble;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 pipe_freeze;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output id_src1, id_src1_vld, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           exe_branch, mem_req, mem_ready, cnt_clr,
    input  pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush,
           pipe_freeze, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src1_vld, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           exe_branch, mem_req, mem_ready, cnt_clr,
    output pc_freeze, ifid_freeze, idex_bubble, ifid_flush, idex_flush,
           pipe_freeze, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : event counter that sticks at all-ones, clear beats increment
// Rev 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         inc,
  input  wire logic         clr,
  output logic [W-1:0]      count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : RAW-hazard stall, branch flush and memory-wait freeze
//                    control for the 5-stage ARM pipeline, with perf counters
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input wire logic          clk,
  input wire logic          rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_mem_stall;
  logic   w_hazard;
  logic   w_pc_freeze;
  logic   w_ifid_freeze;
  logic   w_idex_bubble;
  logic   w_ifid_flush;
  logic   w_idex_flush;
  logic   w_pipe_freeze;
  logic   w_stall_inc;
  logic   w_flush_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // mem_req is ignored once waiting; only mem_ready releases the freeze
  always_comb begin
    w_state_nxt = r_state;
    w_mem_stall = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          w_state_nxt = MEM_WAIT;
          w_mem_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_state_nxt = RUN;
        end else begin
          w_mem_stall = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // forwarding covers everything except a load result still in EXE
      logic w_load_wr;
      assign w_load_wr = bus.exe_wb_en && bus.exe_mem_r_en;
      assign w_hazard  = src_hit(bus.id_src1_vld, bus.id_src1, bus.exe_dest, w_load_wr)
                      || src_hit(bus.id_two_src,  bus.id_src2, bus.exe_dest, w_load_wr);
    end else begin : g_nofwd
      assign w_hazard  = src_hit(bus.id_src1_vld, bus.id_src1, bus.exe_dest, bus.exe_wb_en)
                      || src_hit(bus.id_src1_vld, bus.id_src1, bus.mem_dest, bus.mem_wb_en)
                      || src_hit(bus.id_two_src,  bus.id_src2, bus.exe_dest, bus.exe_wb_en)
                      || src_hit(bus.id_two_src,  bus.id_src2, bus.mem_dest, bus.mem_wb_en);
    end
  endgenerate

  // freeze > branch flush > hazard stall; a frozen branch waits in EXE
  always_comb begin
    w_pc_freeze   = 1'b0;
    w_ifid_freeze = 1'b0;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_pipe_freeze = 1'b0;
    if (rst_n) begin
      if (w_mem_stall) begin
        w_pipe_freeze = 1'b1;
      end else if (bus.exe_branch) begin
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
      end else if (w_hazard) begin
        w_pc_freeze   = 1'b1;
        w_ifid_freeze = 1'b1;
        w_idex_bubble = 1'b1;
      end
    end
  end

  assign bus.pc_freeze   = w_pc_freeze;
  assign bus.ifid_freeze = w_ifid_freeze;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.pipe_freeze = w_pipe_freeze;

  assign w_stall_inc = w_pipe_freeze | w_pc_freeze;
  assign w_flush_inc = w_ifid_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (bus.cnt_clr),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .clr   (bus.cnt_clr),
    .count (bus.flush_cnt)
  );

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline controller that sequences the IF/ID and ID/EX stage registers of the 5-stage ARM core. It detects read-after-write data hazards, applies branch flushes, and freezes the whole pipeline while a data-memory access is outstanding. It also keeps saturating stall and flush performance counters. It sits beside the ID stage; its outputs drive the freeze/flush inputs of the PC, IF/ID, ID/EX, EXE/MEM and MEM/WB registers.

## Interface
- FWD_EN, 0, 1 = forwarding unit present: only load-use hazards stall; 0 = every in-flight writer of a source register stalls
- CNT_W, 16, width of each performance counter
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_src1  in  4  Rn index of the instruction in ID
- id_src1_vld  in  1  instruction in ID reads Rn
- id_src2  in  4  Rm/Rd-for-store index of the instruction in ID
- id_two_src  in  1  instruction in ID reads id_src2
- exe_dest  in  4  destination register of the instruction in EXE
- exe_wb_en, exe_mem_r_en  in  1 each  EXE instruction writes back / is a load
- mem_dest  in  4  destination register of the instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- exe_branch  in  1  branch taken, resolved in EXE
- mem_req  in  1  MEM stage issues a load or store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of both counters
- pc_freeze, ifid_freeze  out  1 each  hold the PC / IF/ID register
- idex_bubble  out  1  load a NOP (all control bits 0) into ID/EX
- ifid_flush, idex_flush  out  1 each  zero the IF/ID / ID/EX register
- pipe_freeze  out  1  hold every pipeline register (memory wait)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- FSM has two states.
  - RUN: if mem_req && !mem_ready, go to MEM_WAIT.
  - MEM_WAIT: on mem_ready, go to RUN; otherwise stay.
- pipe_freeze is Mealy:
  - 1 in RUN when mem_req && !mem_ready.
  - 1 in MEM_WAIT while !mem_ready.
  - 0 in the mem_ready cycle.
- Hazard term, evaluated per source (src1 gated by id_src1_vld, src2 gated by id_two_src):
  - FWD_EN=0: hazard if (exe_wb_en && src==exe_dest) or (mem_wb_en && src==mem_dest).
  - FWD_EN=1: hazard only if exe_mem_r_en && exe_wb_en && src==exe_dest.
- Priority, highest first:
  - pipe_freeze: all other control outputs are 0. A pending branch stays in EXE and is applied after the freeze.
  - exe_branch: ifid_flush = idex_flush = 1. The hazard stall is suppressed.
  - hazard: pc_freeze = ifid_freeze = idex_bubble = 1.
- stall_cnt increments once per cycle in which pipe_freeze or hazard-stall is asserted.
- flush_cnt increments once per cycle in which a flush is asserted.
- Both counters saturate at all-ones and never wrap.
- cnt_clr has priority over increment; the counters read 0 on the next cycle.

## Timing
- All control outputs are combinational from the inputs and the FSM state, usable in the same cycle. The zero-latency path is required because the stage registers sample on the same edge.
- Asynchronous reset (rst_n low):
  - FSM goes to RUN and both counters clear to 0.
  - All control outputs read 0 while rst_n is low.
- Reset asserted during MEM_WAIT aborts the wait. After release the FSM is in RUN regardless of mem_ready.
- mem_req && mem_ready in the same RUN cycle: no freeze and no state change (zero-wait access).
- mem_req held in MEM_WAIT is ignored; only mem_ready exits the state.
- A src equal to both exe_dest and mem_dest gives a single stall per cycle. Counter increments are at most 1 per cycle per counter.

## Structure
- Shared package arm_pipe_pkg holds:
  - the state enum {RUN, MEM_WAIT}
  - REG_IDX_W = 4
  - the NOP control-bundle constant used by idex_bubble consumers
- One sub-module, sat_counter (parameter W; inputs inc, clr), instantiated twice.

## Test plan
- FWD_EN=0, EXE writes R3, ID reads R3 as src1 → pc_freeze = ifid_freeze = idex_bubble = 1 for exactly that cycle; stall_cnt 0→1.
- FWD_EN=1, EXE is a non-load writing R3, ID reads R3 → no stall. Same case with exe_mem_r_en=1 → 1-cycle bubble.
- exe_branch=1 with a simultaneous hazard → ifid_flush = idex_flush = 1, no freeze; flush_cnt +1, stall_cnt unchanged.
- mem_req=1, mem_ready held low 3 cycles then high → pipe_freeze high for 3 cycles and low in the ready cycle; state RUN→MEM_WAIT→RUN; stall_cnt +3.
- During MEM_WAIT with exe_branch=1 → no flush until mem_ready; the flush fires in the mem_ready cycle (branch still in EXE).
- CNT_W=4: 20 stall cycles → stall_cnt sticks at 15. Then cnt_clr → 0. rst_n pulse mid-MEM_WAIT → RUN, counters 0, outputs 0.
